fifo_wr_arb2: RTL

FIFO_WR_ARB2 -- requirements
Module: fifo_wr_arb2

---
 rtl/fifo_arb_pkg.sv | 18 +
 rtl/fifo_arb_stat_cnt.sv | 31 +++
 rtl/fifo_wr_arb2.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the two-requester FIFO write arbiter.
package fifo_arb_pkg;

  localparam int DATA_W_DEF = 36;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    FLUSH = 2'd3
  } arb_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_arb_stat_cnt.sv
// One saturating accepted-beat counter; clear wins over increment.
module fifo_arb_stat_cnt
  import fifo_arb_pkg::*;
(
  input  logic             clock0,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i)
      count_d = '0;
    else if (inc_i)
      count_d = sat_inc(count_q);
  end

  always_ff @(posedge clock0 or posedge reset) begin
    if (reset)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/fifo_wr_arb2.sv
// Two-requester FIFO write arbiter with bounded bursts and pointer flush.
// Per-requester beat statistics are built only when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arb2
  import fifo_arb_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_MAX = 4,
  parameter int FLUSH_CYC = 2
) (
  input  logic              clock0,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              flush_req,
  output logic              flush_busy,
  output logic              fifo_we,
  output logic [DATA_W-1:0] fifo_din,
  output logic              fifo_rst_ptr,
  input  logic              fifo_full,
  input  logic              fifo_fmo,
  output logic              grant_id,
  output logic [CNT_W-1:0]  beats0,
  output logic [CNT_W-1:0]  beats1
);

  localparam int BCNT_W = $clog2(BURST_MAX + 1);
  localparam int FCNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  arb_state_e        state_q;
  logic              grant_q;
  logic [BCNT_W-1:0] burstCnt_q;
  logic [FCNT_W-1:0] flushCnt_q;
  logic              we_q;
  logic [DATA_W-1:0] din_q;
  logic              rstPtr_q;
  logic              busy_q;

  logic              spaceOk;
  logic              acc0, acc1, accept;
  logic [BCNT_W-1:0] burstInc, burstAfter;
  logic              limitHit;

  // A write already on the bus with one slot left will fill the FIFO, so hold off.
  assign spaceOk    = ~fifo_full & ~(we_q & fifo_fmo);
  assign req0_ready = (state_q == GNT0) & spaceOk & ~flush_req;
  assign req1_ready = (state_q == GNT1) & spaceOk & ~flush_req;

  assign acc0   = req0_valid & req0_ready;
  assign acc1   = req1_valid & req1_ready;
  assign accept = acc0 | acc1;

  assign burstInc   = (burstCnt_q >= BCNT_W'(BURST_MAX)) ? burstCnt_q : burstCnt_q + 1'b1;
  assign burstAfter = accept ? burstInc : burstCnt_q;
  assign limitHit   = (burstAfter >= BCNT_W'(BURST_MAX));

  always_ff @(posedge clock0 or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= 1'b1;
      burstCnt_q <= '0;
      flushCnt_q <= '0;
      we_q       <= 1'b0;
      din_q      <= '0;
      rstPtr_q   <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      we_q     <= accept;
      rstPtr_q <= 1'b0;
      busy_q   <= 1'b0;
      if (accept)
        din_q <= acc0 ? req0_data : req1_data;

      if (state_q == FLUSH) begin
        if (flushCnt_q == '0) begin
          state_q <= IDLE;
        end else begin
          flushCnt_q <= flushCnt_q - 1'b1;
          rstPtr_q   <= 1'b1;
          busy_q     <= 1'b1;
        end
      end else if (flush_req) begin
        state_q    <= FLUSH;
        flushCnt_q <= FCNT_W'(FLUSH_CYC - 1);
        rstPtr_q   <= 1'b1;
        busy_q     <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            // On a tie the requester not granted last time wins.
            if (req0_valid && (!req1_valid || grant_q)) begin
              state_q    <= GNT0;
              grant_q    <= 1'b0;
              burstCnt_q <= '0;
            end else if (req1_valid) begin
              state_q    <= GNT1;
              grant_q    <= 1'b1;
              burstCnt_q <= '0;
            end
          end
          GNT0: begin
            if (req1_valid && (limitHit || !req0_valid)) begin
              state_q    <= GNT1;
              grant_q    <= 1'b1;
              burstCnt_q <= '0;
            end else if (!req0_valid) begin
              state_q <= IDLE;
            end else begin
              burstCnt_q <= burstAfter;
            end
          end
          GNT1: begin
            if (req0_valid && (limitHit || !req1_valid)) begin
              state_q    <= GNT0;
              grant_q    <= 1'b0;
              burstCnt_q <= '0;
            end else if (!req1_valid) begin
              state_q <= IDLE;
            end else begin
              burstCnt_q <= burstAfter;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign fifo_we      = we_q;
  assign fifo_din     = din_q;
  assign fifo_rst_ptr = rstPtr_q;
  assign flush_busy   = busy_q;
  assign grant_id     = grant_q;

`ifdef FIFO_ARB_STATS_EN
  logic statClear;
  assign statClear = (state_q == FLUSH) | flush_req;

  fifo_arb_stat_cnt u_cnt0 (
    .clock0  (clock0),
    .reset   (reset),
    .clear_i (statClear),
    .inc_i   (acc0),
    .count_o (beats0)
  );

  fifo_arb_stat_cnt u_cnt1 (
    .clock0  (clock0),
    .reset   (reset),
    .clear_i (statClear),
    .inc_i   (acc1),
    .count_o (beats1)
  );
`else
  assign beats0 = '0;
  assign beats1 = '0;
`endif

endmodule
